// File: rtl/pe2ddr_sched_pkg.sv
// Shared widths, width helper and scheduler state encoding for the PE-to-DDR write-back path.
package pe2ddr_sched_pkg;

  localparam int DDR_ADDR_W = 30;
  localparam int BURST_W    = 8;

  // Bits needed to index n items (at least one bit).
  function automatic int bw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } pe2ddr_sched_state_t;

endpackage

// File: rtl/pe2ddr_chan_slot.sv
// One DDR write channel: busy flag plus held transfer descriptor and PE-group select.
module pe2ddr_chan_slot
  import pe2ddr_sched_pkg::*;
#(
  parameter int GRP_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic [DDR_ADDR_W-1:0] addr,
  input  logic [BURST_W-1:0]    burst,
  input  logic [DDR_ADDR_W-1:0] step,
  input  logic [BURST_W-1:0]    burst_num,
  input  logic [GRP_W-1:0]      sel,
  input  logic                  done,
  output logic                  busy,
  output logic                  start,
  output logic [DDR_ADDR_W-1:0] st_addr,
  output logic [BURST_W-1:0]    ddr_burst,
  output logic [DDR_ADDR_W-1:0] ddr_step,
  output logic [BURST_W-1:0]    ddr_burst_num,
  output logic [GRP_W-1:0]      rd_sel
);

  logic                  busy_q;
  logic [DDR_ADDR_W-1:0] addr_q;
  logic [BURST_W-1:0]    burst_q;
  logic [DDR_ADDR_W-1:0] step_q;
  logic [BURST_W-1:0]    burst_num_q;
  logic [GRP_W-1:0]      sel_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      addr_q      <= '0;
      burst_q     <= '0;
      step_q      <= '0;
      burst_num_q <= '0;
      sel_q       <= '0;
    end else if (issue) begin
      busy_q      <= 1'b1;
      addr_q      <= addr;
      burst_q     <= burst;
      step_q      <= step;
      burst_num_q <= burst_num;
      sel_q       <= sel;
    end else if (done) begin
      busy_q <= 1'b0;
    end
  end

  // The descriptor is visible in the start cycle itself, then held until the next start.
  assign busy          = busy_q;
  assign start         = issue;
  assign st_addr       = issue ? addr      : addr_q;
  assign ddr_burst     = issue ? burst     : burst_q;
  assign ddr_step      = issue ? step      : step_q;
  assign ddr_burst_num = issue ? burst_num : burst_num_q;
  assign rd_sel        = issue ? sel       : sel_q;

endmodule

// File: rtl/pe2ddr_sched.sv
// Splits one write-back command into per-PE-group DDR transfers alternating between ddr1 and ddr2.
module pe2ddr_sched
  import pe2ddr_sched_pkg::*;
#(
  parameter int PE_NUM = 32,
  parameter int GRP_W  = bw(PE_NUM / 4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DDR_ADDR_W-1:0] cmd_base,
  input  logic [DDR_ADDR_W-1:0] cmd_grp_stride,
  input  logic [GRP_W:0]        cmd_grp_num,
  input  logic [BURST_W-1:0]    cmd_burst,
  input  logic [DDR_ADDR_W-1:0] cmd_step,
  input  logic [BURST_W-1:0]    cmd_burst_num,
  output logic                  busy,
  output logic                  all_done,
  output logic [GRP_W-1:0]      rd_sel1,
  output logic [GRP_W-1:0]      rd_sel2,
  output logic                  ddr1_start,
  input  logic                  ddr1_done,
  output logic [DDR_ADDR_W-1:0] ddr1_st_addr,
  output logic [BURST_W-1:0]    ddr1_burst,
  output logic [DDR_ADDR_W-1:0] ddr1_step,
  output logic [BURST_W-1:0]    ddr1_burst_num,
  output logic                  ddr2_start,
  input  logic                  ddr2_done,
  output logic [DDR_ADDR_W-1:0] ddr2_st_addr,
  output logic [BURST_W-1:0]    ddr2_burst,
  output logic [DDR_ADDR_W-1:0] ddr2_step,
  output logic [BURST_W-1:0]    ddr2_burst_num
);

  localparam int GRP_NUM = PE_NUM / 4;

  pe2ddr_sched_state_t   state_q, state_d;
  logic [GRP_W:0]        grp_num_q;
  logic [GRP_W:0]        g_q;
  logic [DDR_ADDR_W-1:0] addr_q;
  logic [DDR_ADDR_W-1:0] stride_q;
  logic [DDR_ADDR_W-1:0] step_q;
  logic [BURST_W-1:0]    burst_q;
  logic [BURST_W-1:0]    burst_num_q;
  logic                  busy1, busy2;
  logic                  issue_any, issue1, issue2;
  logic                  accept;

  assign accept = (state_q == IDLE) && cmd_valid;

  // Strict in-order issue: group g waits for its own channel even if the other is idle.
  assign issue_any = !rst && (state_q == RUN) && (g_q < grp_num_q) && !(g_q[0] ? busy2 : busy1);
  assign issue1    = issue_any && !g_q[0];
  assign issue2    = issue_any &&  g_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grp_num_q   <= '0;
      g_q         <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      step_q      <= '0;
      burst_q     <= '0;
      burst_num_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grp_num_q   <= (cmd_grp_num > (GRP_W+1)'(GRP_NUM)) ? (GRP_W+1)'(GRP_NUM) : cmd_grp_num;
        g_q         <= '0;
        addr_q      <= cmd_base;
        stride_q    <= cmd_grp_stride;
        step_q      <= cmd_step;
        burst_q     <= cmd_burst;
        burst_num_q <= cmd_burst_num;
      end else if (issue_any) begin
        // Running sum gives base + g*stride, wrapping naturally at the address width.
        g_q    <= g_q + 1'b1;
        addr_q <= addr_q + stride_q;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    all_done  = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = RUN;
      end
      RUN: begin
        if ((g_q == grp_num_q) && !busy1 && !busy2) state_d = FIN;
      end
      FIN: begin
        all_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  pe2ddr_chan_slot #(.GRP_W(GRP_W)) u_slot1 (
    .clk           (clk),
    .rst           (rst),
    .issue         (issue1),
    .addr          (addr_q),
    .burst         (burst_q),
    .step          (step_q),
    .burst_num     (burst_num_q),
    .sel           (g_q[GRP_W-1:0]),
    .done          (ddr1_done),
    .busy          (busy1),
    .start         (ddr1_start),
    .st_addr       (ddr1_st_addr),
    .ddr_burst     (ddr1_burst),
    .ddr_step      (ddr1_step),
    .ddr_burst_num (ddr1_burst_num),
    .rd_sel        (rd_sel1)
  );

  pe2ddr_chan_slot #(.GRP_W(GRP_W)) u_slot2 (
    .clk           (clk),
    .rst           (rst),
    .issue         (issue2),
    .addr          (addr_q),
    .burst         (burst_q),
    .step          (step_q),
    .burst_num     (burst_num_q),
    .sel           (g_q[GRP_W-1:0]),
    .done          (ddr2_done),
    .busy          (busy2),
    .start         (ddr2_start),
    .st_addr       (ddr2_st_addr),
    .ddr_burst     (ddr2_burst),
    .ddr_step      (ddr2_step),
    .ddr_burst_num (ddr2_burst_num),
    .rd_sel        (rd_sel2)
  );

endmodule

// File: tb/tb_pe2ddr_sched.sv
// Self-checking bench: per-command schedule predicted from the issue/completion rules, checked every cycle.
module tb_pe2ddr_sched;
  import pe2ddr_sched_pkg::*;

  localparam int GW = 3;
  localparam int MAXG = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid, cmd_ready;
  logic [DDR_ADDR_W-1:0] cmd_base, cmd_grp_stride, cmd_step;
  logic [GW:0]           cmd_grp_num;
  logic [BURST_W-1:0]    cmd_burst, cmd_burst_num;
  logic                  busy, all_done;
  logic [GW-1:0]         rd_sel1, rd_sel2;
  logic                  ddr1_start, ddr1_done, ddr2_start, ddr2_done;
  logic [DDR_ADDR_W-1:0] ddr1_st_addr, ddr1_step, ddr2_st_addr, ddr2_step;
  logic [BURST_W-1:0]    ddr1_burst, ddr1_burst_num, ddr2_burst, ddr2_burst_num;

  always #5 clk = ~clk;

  pe2ddr_sched #(.PE_NUM(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_grp_stride(cmd_grp_stride), .cmd_grp_num(cmd_grp_num),
    .cmd_burst(cmd_burst), .cmd_step(cmd_step), .cmd_burst_num(cmd_burst_num),
    .busy(busy), .all_done(all_done), .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
    .ddr1_start(ddr1_start), .ddr1_done(ddr1_done), .ddr1_st_addr(ddr1_st_addr),
    .ddr1_burst(ddr1_burst), .ddr1_step(ddr1_step), .ddr1_burst_num(ddr1_burst_num),
    .ddr2_start(ddr2_start), .ddr2_done(ddr2_done), .ddr2_st_addr(ddr2_st_addr),
    .ddr2_burst(ddr2_burst), .ddr2_step(ddr2_step), .ddr2_burst_num(ddr2_burst_num)
  );

  int checks = 0;
  int errors = 0;

  // Per-group completion delay in cycles (>= 1), set before each command.
  int dly [MAXG];

  // Values each channel's outputs should currently hold.
  logic [DDR_ADDR_W-1:0] h_addr [2];
  logic [DDR_ADDR_W-1:0] h_step [2];
  logic [BURST_W-1:0]    h_burst [2];
  logic [BURST_W-1:0]    h_bnum [2];
  logic [GW-1:0]         h_sel [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_held();
    for (int c = 0; c < 2; c++) begin
      h_addr[c] = '0; h_step[c] = '0; h_burst[c] = '0; h_bnum[c] = '0; h_sel[c] = '0;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready, 1);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_all_done"}, all_done, 0);
    check({pfx, "_ch1"}, {ddr1_start, ddr1_st_addr, ddr1_burst, ddr1_step, ddr1_burst_num, rd_sel1}, 0);
    check({pfx, "_ch2"}, {ddr2_start, ddr2_st_addr, ddr2_burst, ddr2_step, ddr2_burst_num, rd_sel2}, 0);
  endtask

  task automatic check_chan(input int c, input logic exp_start, input logic obs_start,
                            input logic [DDR_ADDR_W-1:0] a, input logic [BURST_W-1:0] b,
                            input logic [DDR_ADDR_W-1:0] s, input logic [BURST_W-1:0] bn,
                            input logic [GW-1:0] sel, input int t);
    string p;
    p = $sformatf("ch%0d_t%0d", c + 1, t);
    check({p, "_start"}, obs_start, exp_start);
    check({p, "_addr"}, a, h_addr[c]);
    check({p, "_burst"}, b, h_burst[c]);
    check({p, "_step"}, s, h_step[c]);
    check({p, "_bnum"}, bn, h_bnum[c]);
    check({p, "_sel"}, sel, h_sel[c]);
  endtask

  // Issue one command and check every cycle until one cycle after all_done.
  task automatic run_cmd(input logic [DDR_ADDR_W-1:0] base, input logic [DDR_ADDR_W-1:0] stride,
                         input logic [DDR_ADDR_W-1:0] step, input logic [BURST_W-1:0] burst,
                         input logic [BURST_W-1:0] bnum, input int req_n);
    int n, end_t, last_done;
    int s_cyc [MAXG];
    int d_cyc [MAXG];
    logic e1, e2;
    n = (req_n > MAXG) ? MAXG : req_n;
    // Group g starts once the previous group has started and its channel's prior transfer is done.
    for (int g = 0; g < n; g++) begin
      s_cyc[g] = (g == 0) ? 1 : s_cyc[g-1] + 1;
      if (g >= 2 && d_cyc[g-2] + 1 > s_cyc[g]) s_cyc[g] = d_cyc[g-2] + 1;
      d_cyc[g] = s_cyc[g] + dly[g];
    end
    last_done = 0;
    for (int g = 0; g < n; g++) if (d_cyc[g] > last_done) last_done = d_cyc[g];
    end_t = (n == 0) ? 2 : last_done + 2;

    @(negedge clk);
    check("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_base = base; cmd_grp_stride = stride; cmd_step = step;
    cmd_burst = burst; cmd_burst_num = bnum; cmd_grp_num = (GW+1)'(req_n);

    for (int t = 1; t <= end_t + 1; t++) begin
      @(negedge clk);
      e1 = 1'b0; e2 = 1'b0;
      for (int g = 0; g < n; g++) begin
        if (s_cyc[g] == t) begin
          if (g % 2 == 0) e1 = 1'b1; else e2 = 1'b1;
          h_addr[g%2]  = DDR_ADDR_W'(longint'(base) + longint'(g) * longint'(stride));
          h_burst[g%2] = burst; h_step[g%2] = step; h_bnum[g%2] = bnum;
          h_sel[g%2]   = GW'(g);
        end
      end
      check_chan(0, e1, ddr1_start, ddr1_st_addr, ddr1_burst, ddr1_step, ddr1_burst_num, rd_sel1, t);
      check_chan(1, e2, ddr2_start, ddr2_st_addr, ddr2_burst, ddr2_step, ddr2_burst_num, rd_sel2, t);
      check($sformatf("all_done_t%0d", t), all_done, (t == end_t));
      check($sformatf("busy_t%0d", t), busy, (t <= end_t));
      check($sformatf("cmd_ready_t%0d", t), cmd_ready, (t > end_t));

      // Unaccepted garbage commands while not idle; must not disturb the latched one.
      cmd_valid = (t < end_t);
      cmd_base = DDR_ADDR_W'($urandom); cmd_grp_stride = DDR_ADDR_W'($urandom);
      cmd_step = DDR_ADDR_W'($urandom); cmd_burst = BURST_W'($urandom);
      cmd_burst_num = BURST_W'($urandom); cmd_grp_num = (GW+1)'($urandom);
      ddr1_done = 1'b0; ddr2_done = 1'b0;
      for (int g = 0; g < n; g++) begin
        if (d_cyc[g] == t) begin
          if (g % 2 == 0) ddr1_done = 1'b1; else ddr2_done = 1'b1;
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; ddr1_done = 1'b0; ddr2_done = 1'b0;
    cmd_base = '0; cmd_grp_stride = '0; cmd_step = '0; cmd_grp_num = '0;
    cmd_burst = '0; cmd_burst_num = '0;
    clear_held();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Eight groups, fixed 5-cycle completion.
    for (int g = 0; g < MAXG; g++) dly[g] = 5;
    run_cmd(30'h1000, 30'h200, 30'h40, 8'd16, 8'd4, 8);

    // Zero groups.
    run_cmd(30'h2000, 30'h10, 30'h8, 8'd2, 8'd3, 0);

    // ddr1 slow, ddr2 fast: group 2 must wait for ddr1.
    dly[0] = 20; dly[1] = 2; dly[2] = 3;
    run_cmd(30'h0500, 30'h80, 30'h20, 8'd7, 8'd5, 3);

    // Address wrap at 30 bits.
    dly[0] = 1; dly[1] = 1;
    run_cmd(30'h3FFFFF00, 30'h100, 30'h4, 8'd1, 8'd1, 2);

    // Reset while both channels are busy, then late done pulses.
    for (int g = 0; g < MAXG; g++) dly[g] = 30;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 30'h0777; cmd_grp_stride = 30'h10;
    cmd_grp_num = 4'd8; cmd_burst = 8'd9; cmd_step = 30'h3; cmd_burst_num = 8'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_pre_start1", ddr1_start, 1);
    @(negedge clk);
    check("rst_pre_start2", ddr2_start, 1);
    @(negedge clk);
    check("rst_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_held();
    check_reset_state("midrst");
    ddr1_done = 1'b1; ddr2_done = 1'b1;
    @(negedge clk);
    ddr1_done = 1'b0; ddr2_done = 1'b0;
    check_reset_state("late_done_a");
    @(negedge clk);
    check_reset_state("late_done_b");
    for (int g = 0; g < MAXG; g++) dly[g] = 2 + (g % 3);
    run_cmd(30'h0040, 30'h40, 30'h1, 8'd4, 8'd8, 5);

    // Stray ddr2_done in idle, then an over-range group count.
    @(negedge clk);
    ddr2_done = 1'b1;
    @(negedge clk);
    ddr2_done = 1'b0;
    @(negedge clk);
    check("stray_ready", cmd_ready, 1);
    check("stray_busy", busy, 0);
    check("stray_start2", ddr2_start, 0);
    for (int g = 0; g < MAXG; g++) dly[g] = 3;
    run_cmd(30'h8000, 30'h1000, 30'h2, 8'd3, 8'd6, 12);

    // Randomized commands with random completion delays.
    for (int k = 0; k < 12; k++) begin
      for (int g = 0; g < MAXG; g++) dly[g] = $urandom_range(1, 9);
      run_cmd(DDR_ADDR_W'($urandom), DDR_ADDR_W'($urandom), DDR_ADDR_W'($urandom),
              BURST_W'($urandom), BURST_W'($urandom), $urandom_range(0, 11));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
